// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: N:1 valid/ready multiplexer with fixed-select or round-robin grant and one registered output stage
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_data/valid/ready per-channel inputs, channel i at in_data[i*WIDTH +: WIDTH]
//   mode, sel           0 = fixed select on sel, 1 = round-robin over valid channels
//   out_data/chan/valid registered output word, source channel and valid flag
//   out_ready           consumer takes out_data
//   xfer_count          output transfer counter, present only when MUX_XFER_CNT_EN is defined
module mux_rr_nto1 #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_XFER_CNT_EN
    ,
    output logic [15:0]             xfer_count
`endif
);
    logic [SEL_W-1:0] ptr_q, ptr_d, gnt_idx, cand;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic             valid_q, valid_d;
    logic             gnt_any, can_load, xfer;
    logic [NUM_IN-1:0] grant;
    // Round-robin search runs from the farthest offset down so the nearest valid channel after ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (!mode) begin
            gnt_any = (int'(sel) < NUM_IN) && in_valid[sel];
            gnt_idx = sel;
        end else begin
            for (int k = NUM_IN; k >= 1; k--) begin
                cand = SEL_W'((int'(ptr_q) + k) % NUM_IN);
                if (in_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end
    assign can_load = ~valid_q | out_ready;
    assign grant    = gnt_any ? (NUM_IN'(1) << gnt_idx) : '0;
    assign in_ready = grant & {NUM_IN{can_load & ~rst}};
    assign xfer     = |(in_valid & in_ready);
    assign valid_d  = xfer | (valid_q & ~out_ready);
    assign data_d   = xfer ? in_data[gnt_idx*WIDTH +: WIDTH] : data_q;
    assign chan_d   = xfer ? gnt_idx : chan_q;
    assign ptr_d    = (xfer && mode) ? gnt_idx : ptr_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= SEL_W'(NUM_IN - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end
    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;
`ifdef MUX_XFER_CNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (valid_q && out_ready) cnt_q <= cnt_q + 16'd1;
    end
    assign xfer_count = cnt_q;
`endif
endmodule

// File: tb/tb_mux_rr_nto1.sv
// tb_mux_rr_nto1: scoreboard bench for mux_rr_nto1 (reset, fixed select, round-robin, backpressure, wrap, counter)
module tb_mux_rr_nto1;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef MUX_XFER_CNT_EN
    logic [15:0] xfer_count;
`endif
    int n_chk = 0;
    int n_fail = 0;
    logic [9:0]  sb[$];
    logic        m_valid = 1'b0;
    int          m_ptr = 3;
    logic [15:0] m_cnt = '0;
    logic        loaded;
    logic [9:0]  e;

    mux_rr_nto1 dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_XFER_CNT_EN
        , .xfer_count(xfer_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic int exp_grant();
        if (rst || (m_valid && !out_ready)) return -1;
        if (!mode) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 1; k <= 4; k++) if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g = exp_grant();
        return (g < 0) ? 4'b0000 : 4'(1 << g);
    endfunction

    // Advance one clock: push the expected word for a granted transfer, then update the reference state.
    task automatic clk_step();
        int g = exp_grant();
        loaded = 1'b0;
        if (g >= 0) sb.push_back({2'(g), in_data[g*8 +: 8]});
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_ptr = 3; m_cnt = '0; sb.delete();
        end else begin
            if (m_valid && out_ready) m_cnt = m_cnt + 16'd1;
            if (g >= 0) begin
                m_valid = 1'b1; loaded = 1'b1;
                if (mode) m_ptr = g;
            end else if (out_ready) m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic set_rr_data();
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; set_rr_data();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
            clk_step();
        end
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
            n_fail++; $display("FAIL reset_outputs got v=%b d=%h c=%0d exp v=0 d=00 c=0", out_valid, out_data, out_chan);
        end
        @(negedge clk); rst = 1'b0; in_valid = 4'b0000;
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_data = 32'h00A5_0000; in_valid = 4'b0100; out_ready = 1'b1;
        #1;
        n_chk++; if (in_ready !== 4'b0100 || in_ready !== exp_ready()) begin n_fail++; $display("FAIL fixed_in_ready got=%b exp=0100", in_ready); end
        clk_step();
        n_chk++;
        if (!loaded || sb.size() == 0) begin n_fail++; $display("FAIL fixed_load got=none exp=one word"); end
        else begin
            e = sb.pop_front();
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 2'd2 || {out_chan, out_data} !== e) begin
                n_fail++; $display("FAIL fixed_out got v=%b d=%h c=%0d exp v=1 d=a5 c=2", out_valid, out_data, out_chan);
            end
        end
        @(negedge clk); in_valid = 4'b0000;
        clk_step();
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_chan !== 2'd2) begin
            n_fail++; $display("FAIL drain_hold got v=%b d=%h c=%0d exp v=0 d=a5 c=2", out_valid, out_data, out_chan);
        end
    endtask

    task automatic test_rr_fair();
        logic [7:0] seq[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        @(negedge clk); mode = 1'b1; set_rr_data(); in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_chk++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_ready()); end
            clk_step();
            e = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== seq[i] || {out_chan, out_data} !== e) begin
                n_fail++; $display("FAIL rr_seq[%0d] got d=%h c=%0d v=%b exp d=%h", i, out_data, out_chan, out_valid, seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk); clk_step();
        e = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
        n_chk++; if (out_data !== 8'h11 || {out_chan, out_data} !== e) begin n_fail++; $display("FAIL bp_pre got=%h exp=11", out_data); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); out_ready = 1'b0; #1;
            n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", i, in_ready); end
            clk_step();
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== 8'h11 || out_chan !== 2'd1) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%b d=%h c=%0d exp v=1 d=11 c=1", i, out_valid, out_data, out_chan);
            end
        end
        @(negedge clk); out_ready = 1'b1; #1;
        n_chk++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready); end
        clk_step();
        e = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
        n_chk++; if (out_data !== 8'h12 || {out_chan, out_data} !== e) begin n_fail++; $display("FAIL bp_release got=%h exp=12", out_data); end
    endtask

    task automatic test_sparse_wrap();
        logic [3:0] pat[4] = '{4'b1000, 4'b0010, 4'b1010, 4'b1010};
        logic [1:0] ch[4]  = '{2'd3, 2'd1, 2'd3, 2'd1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); in_valid = pat[i]; #1;
            n_chk++; if (in_ready !== 4'(1 << ch[i])) begin n_fail++; $display("FAIL wrap_grant[%0d] got=%b exp_ch=%0d", i, in_ready, ch[i]); end
            clk_step();
            e = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
            n_chk++;
            if (out_chan !== ch[i] || {out_chan, out_data} !== e) begin
                n_fail++; $display("FAIL wrap_out[%0d] got c=%0d d=%h exp c=%0d", i, out_chan, out_data, ch[i]);
            end
        end
        @(negedge clk); in_valid = 4'b0000; clk_step();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drain got v=%b exp v=0", out_valid); end
    endtask

`ifdef MUX_XFER_CNT_EN
    task automatic test_counter();
        int guard = 0;
        @(negedge clk); rst = 1'b1; clk_step();
        @(negedge clk); rst = 1'b0; #1;
        n_chk++; if (xfer_count !== 16'h0000) begin n_fail++; $display("FAIL cnt_reset got=%h exp=0000", xfer_count); end
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        while (m_cnt != 16'hFFFF && guard < 70000) begin clk_step(); sb.delete(); guard++; end
        n_chk++; if (xfer_count !== 16'hFFFF || m_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_full got=%h exp=ffff", xfer_count); end
        clk_step();
        n_chk++; if (xfer_count !== 16'h0000) begin n_fail++; $display("FAIL cnt_wrap got=%h exp=0000", xfer_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_fixed();
        test_rr_fair();
        test_backpressure();
        test_sparse_wrap();
`ifdef MUX_XFER_CNT_EN
        test_counter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
